// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch controller
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES      = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - single-outstanding instruction fetch FSM with redirect/kill handling
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = fetch_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  import fetch_pkg::*;

  fetch_state_t state_q, state_d;
  logic         kill_q, kill_d;
  logic [31:0]  pc_q, pc_d;
  logic         if_valid_q, if_valid_d;
  logic [31:0]  if_pc_q, if_pc_d;
  logic [31:0]  if_instr_q, if_instr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      kill_q     <= 1'b0;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_pc_q    <= RESET_PC;
      if_instr_q <= NOP_INSTR;
    end else begin
      state_q    <= state_d;
      kill_q     <= kill_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    kill_d     = kill_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;

    if (redirect) begin
      pc_d       = word_align(redirect_pc);
      if_valid_d = 1'b0;
      if_instr_d = NOP_INSTR;
      // A request already granted (or still in flight) must have its response dropped.
      case (state_q)
        REQ: begin
          state_d = imem_gnt ? RESP : REQ;
          kill_d  = imem_gnt;
        end
        RESP: begin
          state_d = imem_rvalid ? REQ : RESP;
          kill_d  = !imem_rvalid;
        end
        default: begin
          state_d = REQ;
          kill_d  = 1'b0;
        end
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          state_d = REQ;
          pc_d    = RESET_PC;
        end
        REQ: begin
          if (imem_gnt) state_d = RESP;
        end
        RESP: begin
          if (imem_rvalid) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = REQ;
            end else begin
              if_instr_d = imem_rdata;
              if_pc_d    = pc_q;
              if_valid_d = 1'b1;
              pc_d       = pc_q + INSTR_BYTES;
              state_d    = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            if_valid_d = 1'b0;
            state_d    = REQ;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign imem_req  = (state_q == REQ);
  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013: instruction presented on bubbles and flushes.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock, sole clock domain.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 imem_req  out  1  fetch request to instruction memory.
REQ-007 imem_addr  out  32  fetch address, word-aligned.
REQ-008 imem_gnt  in  1  memory accepted the request this cycle.
REQ-009 imem_rvalid  in  1  read data valid this cycle.
REQ-010 imem_rdata  in  32  fetched instruction.
REQ-011 stall  in  1  decode cannot accept (load-use hazard).
REQ-012 redirect  in  1  branch/jump taken; refetch from redirect_pc.
REQ-013 redirect_pc  in  32  redirect target; bits [1:0] SHALL be forced to 0 internally.
REQ-014 if_valid  out  1  if_pc/if_instr hold a valid fetched instruction.
REQ-015 if_pc  out  32  address of the presented instruction.
REQ-016 if_instr  out  32  presented instruction.

Function
REQ-017 FSM states SHALL be IDLE, REQ, RESP, HOLD; at most one memory request outstanding.
REQ-018 IDLE: entered only from reset; SHALL move to REQ on the next clock with fetch pointer pc = RESET_PC.
REQ-019 REQ: imem_req=1, imem_addr=pc, both stable until imem_gnt; on imem_gnt SHALL move to RESP.
REQ-020 RESP: imem_req=0; on imem_rvalid (kill=0) SHALL register if_instr=imem_rdata, if_pc=pc, if_valid=1, pc=pc+4 (mod 2^32), and move to HOLD.
REQ-021 HOLD: outputs held; stall=1 SHALL remain in HOLD; stall=0 SHALL consume the instruction, clear if_valid on the next edge, and move to REQ.
REQ-022 Latency: gnt at cycle n, rvalid at cycle n+k (k>=1) SHALL give if_valid=1 from cycle n+k+1; minimum 3 cycles per instruction.
REQ-023 imem_gnt outside REQ and imem_rvalid outside RESP SHALL be ignored.
REQ-024 redirect SHALL take priority over stall and all other events in every state except reset.
REQ-025 On redirect: pc=redirect_pc, if_valid=0, if_instr=NOP_INSTR on the next edge.
REQ-026 Redirect in IDLE, HOLD, or REQ without gnt SHALL go to REQ, issuing redirect_pc the next cycle.
REQ-027 Redirect in REQ with gnt in the same cycle SHALL go to RESP with kill=1.
REQ-028 Redirect in RESP without rvalid SHALL stay in RESP with kill=1; with rvalid in the same cycle SHALL discard the data and go to REQ, kill=0.
REQ-029 RESP with kill=1 and rvalid SHALL discard the data, clear kill, go to REQ, and leave if_valid=0.
REQ-030 A second redirect while kill=1 SHALL only update pc.

Reset
REQ-031 rst_n low SHALL immediately force: state=IDLE, kill=0, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=RESET_PC, if_instr=NOP_INSTR.
REQ-032 Reset during RESP SHALL abandon the outstanding request; the bench SHALL NOT return rvalid for it after release.

Structure
REQ-033 Package fetch_pkg SHALL hold fetch_state_t (IDLE, REQ, RESP, HOLD), NOP_INSTR and the RESET_PC default.
REQ-034 Single module; no sub-module; all outputs registered except imem_req, imem_addr, which decode from state/pc.

Verification
REQ-035 Reset release, gnt immediate, rvalid 1 cycle later, data 32'hDEAD_0001 -> if_valid at cycle 3 with if_pc=0, if_instr=32'hDEAD_0001; next imem_addr=4.
REQ-036 stall=1 for 5 cycles while HOLD -> if_pc/if_instr constant, imem_req=0 throughout; first request after stall drops at addr 4.
REQ-037 Redirect to 32'h0000_0100 while in HOLD with stall=1 -> if_valid=0 next cycle, imem_addr=0x100.
REQ-038 Redirect to 32'h0000_0200 in RESP, rvalid 2 cycles later with 32'hBAD0_BAD0 -> data never shown; next request addr 0x200.
REQ-039 pc=32'hFFFF_FFFC fetched -> next imem_addr=0 (wrap).
REQ-040 rst_n low mid-RESP -> outputs at reset values asynchronously; first post-reset request at RESET_PC.
